vcdemux: RTL and testbench

- Receive-side counterpart of the output VC multiplexer.
- Takes the single physical link carrying flits tagged with a virtual-channel id. Steers each flit into one of two per-VC FIFOs. Presents each VC as an independent valid/ready stream to the router input stage.
- Returns one credit pulse per dequeued flit to the upstream credit counter.
- Sits at every router input port, between the link and the routing/VC-allocation logic.

---
 rtl/vcdemux_if.sv | 33 +++
 rtl/vcdemux.sv | 99 +++++++++
 tb/tb_vcdemux.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/vcdemux_if.sv
// Link-side and per-VC stream signals of the receive VC demultiplexer.
// The slave modport is the demux's view. The master modport is the view of whatever drives the link and consumes the VCs.
interface vcdemux_if #(
    parameter int DATAW = 32,
    parameter int VCHW  = 1
);
    logic             ivalid;
    logic [DATAW-1:0] idata;
    logic [VCHW-1:0]  ivch;
    logic             ordy0;
    logic             ordy1;
    logic             ovalid0;
    logic             ovalid1;
    logic [DATAW-1:0] odata0;
    logic [DATAW-1:0] odata1;
    logic             credit0;
    logic             credit1;
    logic             full0;
    logic             full1;
    logic             err;

    modport slave (
        input  ivalid, idata, ivch, ordy0, ordy1,
        output ovalid0, ovalid1, odata0, odata1,
        output credit0, credit1, full0, full1, err
    );

    modport master (
        output ivalid, idata, ivch, ordy0, ordy1,
        input  ovalid0, ovalid1, odata0, odata1,
        input  credit0, credit1, full0, full1, err
    );
endinterface

// File: rtl/vcdemux.sv
// Receive-side VC demultiplexer: steers link flits into two independent per-VC FIFOs.
// Each dequeue returns a registered credit pulse upstream.
module vcdemux #(
    parameter int DATAW = 32,
    parameter int VCHW  = 1,
    parameter int DEPTH = 4,
    parameter int CNTW  = 3
) (
    input  logic           clk,
    input  logic           rst_,
    vcdemux_if.slave       bus
);
    localparam int PTRW = $clog2(DEPTH);

    logic [DATAW-1:0] mem [2][DEPTH];
    logic [PTRW-1:0]  wptr [2];
    logic [PTRW-1:0]  rptr [2];
    logic [CNTW-1:0]  cnt  [2];
    logic [DATAW-1:0] head [2];

    logic [1:0] rdy;
    logic [1:0] vld;
    logic [1:0] full;
    logic [1:0] wr;
    logic [1:0] rd;
    logic [1:0] acc;
    logic [1:0] ovf;
    logic [1:0] credit_p1;
    logic       err_q;

    // Request decode; a full FIFO still takes a write when it is being read in the same cycle
    always_comb begin
        rdy  = {bus.ordy1, bus.ordy0};
        vld  = '0;
        full = '0;
        wr   = '0;
        rd   = '0;
        acc  = '0;
        ovf  = '0;
        for (int i = 0; i < 2; i++) begin
            vld[i]  = (cnt[i] != '0);
            full[i] = (cnt[i] == CNTW'(DEPTH));
            rd[i]   = vld[i] & rdy[i];
            wr[i]   = bus.ivalid & (bus.ivch == VCHW'(i));
            acc[i]  = wr[i] & (~full[i] | rd[i]);
            ovf[i]  = wr[i] & full[i] & ~rd[i];
            head[i] = vld[i] ? mem[i][rptr[i]] : '0;
        end
    end

    // Flit storage is never reset; stale entries are hidden behind the zero count
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (acc[i]) begin
                mem[i][wptr[i]] <= bus.idata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_) begin
            for (int i = 0; i < 2; i++) begin
                wptr[i] <= '0;
                rptr[i] <= '0;
                cnt[i]  <= '0;
            end
            credit_p1 <= '0;
            err_q     <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (acc[i]) begin
                    wptr[i] <= wptr[i] + PTRW'(1);
                end
                if (rd[i]) begin
                    rptr[i] <= rptr[i] + PTRW'(1);
                end
                case ({acc[i], rd[i]})
                    2'b10:   cnt[i] <= cnt[i] + CNTW'(1);
                    2'b01:   cnt[i] <= cnt[i] - CNTW'(1);
                    default: cnt[i] <= cnt[i];
                endcase
            end
            credit_p1 <= rd;
            if (|ovf) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.ovalid0 = vld[0];
    assign bus.ovalid1 = vld[1];
    assign bus.odata0  = head[0];
    assign bus.odata1  = head[1];
    assign bus.full0   = full[0];
    assign bus.full1   = full[1];
    assign bus.credit0 = credit_p1[0];
    assign bus.credit1 = credit_p1[1];
    assign bus.err     = err_q;
endmodule

// File: tb/tb_vcdemux.sv
// Bench for vcdemux: directed scenarios plus randomized traffic, checked every cycle against a queue-based model.
module tb_vcdemux;
    localparam int DATAW = 32;
    localparam int DEPTH = 4;

    logic clk;
    logic rst_;
    int   n_chk;
    int   n_err;

    vcdemux_if #(.DATAW(DATAW), .VCHW(1)) bif ();

    vcdemux #(.DATAW(DATAW), .VCHW(1), .DEPTH(DEPTH), .CNTW(3)) dut (
        .clk  (clk),
        .rst_ (rst_),
        .bus  (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: per-VC queues, expected credits and sticky error
    logic [DATAW-1:0] q0[$];
    logic [DATAW-1:0] q1[$];
    logic ecr0, ecr1, eerr;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        bit r0, r1, w0, w1, a0, a1;
        logic [DATAW-1:0] d;
        @(negedge clk);
        chk("ovalid0", 64'(bif.ovalid0), 64'(q0.size() != 0));
        chk("ovalid1", 64'(bif.ovalid1), 64'(q1.size() != 0));
        chk("odata0",  64'(bif.odata0),  64'(q0.size() != 0 ? q0[0] : '0));
        chk("odata1",  64'(bif.odata1),  64'(q1.size() != 0 ? q1[0] : '0));
        chk("full0",   64'(bif.full0),   64'(q0.size() == DEPTH));
        chk("full1",   64'(bif.full1),   64'(q1.size() == DEPTH));
        chk("credit0", 64'(bif.credit0), 64'(ecr0));
        chk("credit1", 64'(bif.credit1), 64'(ecr1));
        chk("err",     64'(bif.err),     64'(eerr));
        r0 = (q0.size() != 0) && bif.ordy0;
        r1 = (q1.size() != 0) && bif.ordy1;
        w0 = bif.ivalid && (bif.ivch == 1'b0);
        w1 = bif.ivalid && (bif.ivch == 1'b1);
        a0 = w0 && ((q0.size() < DEPTH) || r0);
        a1 = w1 && ((q1.size() < DEPTH) || r1);
        d  = bif.idata;
        @(posedge clk);
        #1;
        if (rst_) begin
            q0.delete();
            q1.delete();
            ecr0 = 1'b0;
            ecr1 = 1'b0;
            eerr = 1'b0;
        end else begin
            if (r0) void'(q0.pop_front());
            if (r1) void'(q1.pop_front());
            if (a0) q0.push_back(d);
            if (a1) q1.push_back(d);
            ecr0 = r0;
            ecr1 = r1;
            if ((w0 && !a0) || (w1 && !a1)) eerr = 1'b1;
        end
    endtask

    task automatic drive(input bit v, input bit vch, input logic [DATAW-1:0] d, input bit r0, input bit r1);
        bif.ivalid = v;
        bif.ivch   = vch;
        bif.idata  = d;
        bif.ordy0  = r0;
        bif.ordy1  = r1;
    endtask

    task automatic do_reset();
        rst_ = 1'b1;
        tick();
        rst_ = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        n_chk = 0;
        n_err = 0;
        ecr0 = 1'b0; ecr1 = 1'b0; eerr = 1'b0;
        rst_ = 1'b1;
        drive(0, 0, '0, 0, 0);
        @(posedge clk);
        #1;
        do_reset();
        chk("rst_ovalid0", 64'(bif.ovalid0), 64'd0);
        chk("rst_full0",   64'(bif.full0),   64'd0);
        chk("rst_err",     64'(bif.err),     64'd0);

        // Single flit through VC0
        drive(1, 0, 32'hA5A5_0001, 0, 0);
        tick();
        chk("t1_ovalid0", 64'(bif.ovalid0), 64'd1);
        chk("t1_odata0",  64'(bif.odata0),  64'hA5A5_0001);
        chk("t1_ovalid1", 64'(bif.ovalid1), 64'd0);
        drive(0, 0, '0, 1, 0);
        tick();
        chk("t1_credit0", 64'(bif.credit0), 64'd1);
        chk("t1_empty0",  64'(bif.ovalid0), 64'd0);

        // Fill VC1 then drain in order
        for (int k = 1; k <= 4; k++) begin
            drive(1, 1, DATAW'(k), 0, 0);
            tick();
        end
        chk("t2_full1", 64'(bif.full1), 64'd1);
        drive(0, 0, '0, 0, 1);
        for (int k = 1; k <= 4; k++) begin
            chk("t2_odata1", 64'(bif.odata1), 64'(k));
            tick();
            chk("t2_credit1", 64'(bif.credit1), 64'd1);
        end
        drive(0, 0, '0, 0, 0);
        tick();
        chk("t2_empty1", 64'(bif.ovalid1), 64'd0);

        // Write into a full VC1 while it is being read
        for (int k = 1; k <= 4; k++) begin
            drive(1, 1, DATAW'(k), 0, 0);
            tick();
        end
        drive(1, 1, 32'd5, 0, 1);
        tick();
        chk("t3_full1",  64'(bif.full1),  64'd1);
        chk("t3_err",    64'(bif.err),    64'd0);
        chk("t3_odata1", 64'(bif.odata1), 64'd2);
        drive(0, 0, '0, 0, 1);
        for (int k = 2; k <= 5; k++) begin
            chk("t3_order", 64'(bif.odata1), 64'(k));
            tick();
        end

        // Overflow of VC0 drops the flit and latches err
        for (int k = 1; k <= 4; k++) begin
            drive(1, 0, DATAW'(100 + k), 0, 0);
            tick();
        end
        drive(1, 0, 32'd9, 0, 0);
        tick();
        chk("t4_err", 64'(bif.err), 64'd1);
        drive(0, 0, '0, 1, 0);
        for (int k = 1; k <= 4; k++) begin
            chk("t4_drain", 64'(bif.odata0), 64'(100 + k));
            tick();
        end
        chk("t4_empty0",  64'(bif.ovalid0), 64'd0);
        chk("t4_errheld", 64'(bif.err),     64'd1);

        // Interleaved VCs and pointer wrap
        do_reset();
        drive(1, 0, 32'd10, 0, 0); tick();
        drive(1, 1, 32'd20, 0, 0); tick();
        drive(1, 0, 32'd11, 0, 0); tick();
        drive(1, 1, 32'd21, 0, 0); tick();
        chk("t5_vc0a", 64'(bif.odata0), 64'd10);
        chk("t5_vc1a", 64'(bif.odata1), 64'd20);
        drive(0, 0, '0, 1, 1); tick();
        chk("t5_vc0b", 64'(bif.odata0), 64'd11);
        chk("t5_vc1b", 64'(bif.odata1), 64'd21);
        tick();
        for (int k = 0; k < 12; k++) begin
            drive(1, 0, DATAW'(32'h100 + k), 1, 1); tick();
            drive(1, 1, DATAW'(32'h200 + k), 1, 1); tick();
        end
        drive(0, 0, '0, 1, 1);
        tick();
        tick();

        // Reset with flits queued discards them without credits
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, DATAW'(32'h300 + k), 0, 0);
            tick();
        end
        drive(1, 0, 32'hDEAD, 1, 1);
        do_reset();
        drive(0, 0, '0, 0, 0);
        chk("t6_ovalid0", 64'(bif.ovalid0), 64'd0);
        chk("t6_full0",   64'(bif.full0),   64'd0);
        chk("t6_err",     64'(bif.err),     64'd0);
        tick();
        chk("t6_credit0", 64'(bif.credit0), 64'd0);

        // Randomized traffic with phases of light and heavy back-pressure
        for (int n = 0; n < 3000; n++) begin
            int rp;
            rp = ((n / 150) % 2 == 0) ? 25 : 80;
            drive($urandom_range(99) < 70, 1'($urandom), $urandom,
                  $urandom_range(99) < rp, $urandom_range(99) < rp);
            rst_ = ($urandom_range(399) == 0);
            tick();
        end
        rst_ = 1'b0;
        drive(0, 0, '0, 0, 0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
